line_stepper: RTL

Sequential line rasterizer for the geometric shapes unit. It accepts one segment (x0,y0)→(x1,y1) in signed two's-complement coordinates. It picks the major axis with a strict absolute-magnitude comparison (|dx| > |dy| selects x-major; a tie selects y-major). It then streams every pixel of the segment, endpoints included, one per cycle over a valid/ready handshake using integer Bresenham stepping. It sits between the shape command decoder and the pixel writer.

---
 rtl/line_stepper.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/line_stepper.sv
// Bresenham line rasterizer: accepts one signed segment and streams every pixel,
// endpoints included, one per cycle over a valid/ready handshake.
module line_stepper #(
   parameter int N = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] x0,
   input  logic signed [N-1:0] y0,
   input  logic signed [N-1:0] x1,
   input  logic signed [N-1:0] y1,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] out_x,
   output logic signed [N-1:0] out_y,
   output logic                out_last,
   output logic                major_x,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t state, state_next;

   logic signed [N-1:0] lat_x0, lat_y0, lat_x1, lat_y1;
   logic signed [N-1:0] cx, cy;
   logic                sx_neg, sy_neg;
   logic        [N:0]   remaining;
   logic signed [N+2:0] err;
   logic signed [N+2:0] err_inc_flat;
   logic signed [N+2:0] err_inc_diag;

   logic signed [N:0]   dx, dy;
   logic        [N:0]   ax, ay;
   logic        [N:0]   maj, mnr;
   logic                setup_major_x;
   logic signed [N+2:0] two_min;
   logic signed [N+2:0] err_init;
   logic signed [N+2:0] diag_inc;
   logic                step_minor;
   logic                handshake;

   // Differences are taken one bit wider than the coordinates so |x1-x0| never overflows.
   always_comb begin
      dx            = {lat_x1[N-1], lat_x1} - {lat_x0[N-1], lat_x0};
      dy            = {lat_y1[N-1], lat_y1} - {lat_y0[N-1], lat_y0};
      ax            = dx[N] ? -dx : dx;
      ay            = dy[N] ? -dy : dy;
      setup_major_x = (ax > ay);
      maj           = setup_major_x ? ax : ay;
      mnr           = setup_major_x ? ay : ax;
      two_min       = {1'b0, mnr, 1'b0};
      err_init      = two_min - {2'b00, maj};
      diag_inc      = two_min - {1'b0, maj, 1'b0};
   end

   function automatic logic signed [N-1:0] step_coord(input logic signed [N-1:0] v,
                                                      input logic neg);
      return v + {{(N-1){neg}}, 1'b1};
   endfunction

   assign handshake  = (state == RUN) && out_ready;
   assign step_minor = ~err[N+2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = SETUP;
         SETUP:   state_next = RUN;
         RUN:     if (out_ready && (remaining == '0)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == RUN);
      out_last  = (state == RUN) && (remaining == '0);
      out_x     = cx;
      out_y     = cy;
   end

   // The error term decides whether the minor axis advances alongside the major one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_x0       <= '0;
         lat_y0       <= '0;
         lat_x1       <= '0;
         lat_y1       <= '0;
         cx           <= '0;
         cy           <= '0;
         sx_neg       <= 1'b0;
         sy_neg       <= 1'b0;
         major_x      <= 1'b0;
         remaining    <= '0;
         err          <= '0;
         err_inc_flat <= '0;
         err_inc_diag <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  lat_x0 <= x0;
                  lat_y0 <= y0;
                  lat_x1 <= x1;
                  lat_y1 <= y1;
               end
            end
            SETUP: begin
               cx           <= lat_x0;
               cy           <= lat_y0;
               sx_neg       <= dx[N];
               sy_neg       <= dy[N];
               major_x      <= setup_major_x;
               remaining    <= maj;
               err          <= err_init;
               err_inc_flat <= two_min;
               err_inc_diag <= diag_inc;
            end
            RUN: begin
               if (handshake && (remaining != '0)) begin
                  if (major_x) begin
                     cx <= step_coord(cx, sx_neg);
                     if (step_minor) cy <= step_coord(cy, sy_neg);
                  end else begin
                     cy <= step_coord(cy, sy_neg);
                     if (step_minor) cx <= step_coord(cx, sx_neg);
                  end
                  err       <= step_minor ? (err + err_inc_diag) : (err + err_inc_flat);
                  remaining <= remaining - {{N{1'b0}}, 1'b1};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
